// File: rtl/store_align_buffer.sv
// rtl/store_align_buffer.sv - store lane aligner with a small in-order write buffer
module store_align_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_op,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        err_valid,
  output logic [31:0] err_addr,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [PW:0]   count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic [29:0] q_addr  [DEPTH];
  logic [3:0]  q_be    [DEPTH];
  logic [31:0] q_wdata [DEPTH];

  logic        accept;
  logic        legal;
  logic        push;
  logic        pop;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;

  assign in_ready  = (count < FULL_COUNT);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign mem_valid = (count != '0);
  assign pop       = mem_valid && mem_ready;
  assign empty     = (count == '0);

  assign mem_addr  = {q_addr[head], 2'b00};
  assign mem_wdata = q_wdata[head];
  assign mem_be    = q_be[head];

  // Decode op and low address bits into legality, byte enables and replicated data
  always_comb begin
    legal      = 1'b0;
    lane_be    = 4'b0000;
    lane_wdata = in_data;
    case (in_op)
      2'b00: begin
        legal      = (in_addr[1:0] == 2'b00);
        lane_be    = 4'b1111;
        lane_wdata = in_data;
      end
      2'b01: begin
        legal      = 1'b1;
        lane_be    = 4'b0001 << in_addr[1:0];
        lane_wdata = {4{in_data[7:0]}};
      end
      2'b10: begin
        legal      = !in_addr[0];
        lane_be    = in_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{in_data[15:0]}};
      end
      default: begin
        legal      = 1'b0;
        lane_be    = 4'b0000;
        lane_wdata = in_data;
      end
    endcase
  end

  // Occupancy and ring pointers; push and pop in the same cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, cleared on reset so the memory outputs read zero when idle after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i]  <= '0;
        q_be[i]    <= '0;
        q_wdata[i] <= '0;
      end
    end else if (push) begin
      q_addr[tail]  <= in_addr[31:2];
      q_be[tail]    <= lane_be;
      q_wdata[tail] <= lane_wdata;
    end
  end

  // One-cycle rejection pulse; the address sticks until the next rejection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_valid <= accept && !legal;
      if (accept && !legal) err_addr <= in_addr;
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// tb/tb_store_align_buffer.sv - directed bench for store_align_buffer
module tb_store_align_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        empty;

  int tests;
  int fails;

  store_align_buffer #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_op     (in_op),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    in_valid = v;
    in_op    = op;
    in_addr  = a;
    in_data  = d;
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  d;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);

    // Reset state
    tick(); tick();
    check1 ("rst_mem_valid", mem_valid, 1'b0);
    check32("rst_mem_addr",  mem_addr,  32'h0);
    check32("rst_mem_wdata", mem_wdata, 32'h0);
    check4 ("rst_mem_be",    mem_be,    4'b0000);
    check1 ("rst_err_valid", err_valid, 1'b0);
    check32("rst_err_addr",  err_addr,  32'h0);
    check1 ("rst_in_ready",  in_ready,  1'b1);
    check1 ("rst_empty",     empty,     1'b1);
    rst_n = 1'b1;
    tick();

    // sb at 0x1003
    drive(1'b1, 2'b01, 32'h0000_1003, 32'h0000_00A5);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check1 ("sb_mem_valid", mem_valid, 1'b1);
    check32("sb_mem_addr",  mem_addr,  32'h0000_1000);
    check4 ("sb_mem_be",    mem_be,    4'b1000);
    check32("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    check1 ("sb_empty",     empty,     1'b0);
    mem_ready = 1'b1;
    tick();
    check1 ("sb_drained_empty", empty,     1'b1);
    check1 ("sb_drained_valid", mem_valid, 1'b0);

    // sh at 0x2002 with memory ready
    drive(1'b1, 2'b10, 32'h0000_2002, 32'h0000_BEEF);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check1 ("sh_mem_valid", mem_valid, 1'b1);
    check32("sh_mem_addr",  mem_addr,  32'h0000_2000);
    check4 ("sh_mem_be",    mem_be,    4'b1100);
    check32("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
    tick();
    check1 ("sh_popped_empty", empty, 1'b1);

    // Misaligned word, then reserved op
    drive(1'b1, 2'b00, 32'h0000_3001, 32'h1234_5678);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check1 ("err1_valid",     err_valid, 1'b1);
    check32("err1_addr",      err_addr,  32'h0000_3001);
    check1 ("err1_mem_valid", mem_valid, 1'b0);
    check1 ("err1_empty",     empty,     1'b1);
    tick();
    check1 ("err1_cleared",   err_valid, 1'b0);
    check32("err1_addr_held", err_addr,  32'h0000_3001);
    drive(1'b1, 2'b11, 32'h0000_4000, 32'h0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check1 ("err2_valid",     err_valid, 1'b1);
    check32("err2_addr",      err_addr,  32'h0000_4000);
    check1 ("err2_mem_valid", mem_valid, 1'b0);
    tick();
    check1 ("err2_cleared",   err_valid, 1'b0);
    // Misaligned half is also rejected
    drive(1'b1, 2'b10, 32'h0000_5001, 32'h0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check1 ("err3_valid", err_valid, 1'b1);
    check32("err3_addr",  err_addr,  32'h0000_5001);
    check1 ("err3_empty", empty,     1'b1);
    tick();

    // Fill with memory stalled, third request waits
    mem_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_0100, 32'h1111_1111);
    tick();
    check1 ("fill1_in_ready", in_ready, 1'b1);
    drive(1'b1, 2'b01, 32'h0000_0201, 32'h0000_0022);
    tick();
    check1 ("fill2_in_ready", in_ready, 1'b0);
    drive(1'b1, 2'b10, 32'h0000_0300, 32'h0000_3333);
    tick();
    check1 ("full_in_ready",   in_ready,  1'b0);
    check32("stall_addr_a",    mem_addr,  32'h0000_0100);
    check4 ("stall_be_a",      mem_be,    4'b1111);
    check32("stall_wdata_a",   mem_wdata, 32'h1111_1111);
    tick();
    check32("stall_addr_b",    mem_addr,  32'h0000_0100);
    check32("stall_wdata_b",   mem_wdata, 32'h1111_1111);
    mem_ready = 1'b1;
    tick();
    check32("pop1_addr",     mem_addr,  32'h0000_0200);
    check4 ("pop1_be",       mem_be,    4'b0010);
    check32("pop1_wdata",    mem_wdata, 32'h2222_2222);
    check1 ("pop1_in_ready", in_ready,  1'b1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check32("pop2_addr",  mem_addr,  32'h0000_0300);
    check4 ("pop2_be",    mem_be,    4'b0011);
    check32("pop2_wdata", mem_wdata, 32'h3333_3333);
    check1 ("pop2_valid", mem_valid, 1'b1);
    tick();
    check1 ("pop3_empty", empty, 1'b1);

    // Streaming eight byte stores with memory always ready
    for (int i = 0; i < 8; i++) begin
      a = 32'h8000_0000 + 32'(i * 5);
      d = 8'h10 + 8'(i);
      drive(1'b1, 2'b01, a, {24'h0, d});
      tick();
      check1 ($sformatf("strm%0d_valid", i), mem_valid, 1'b1);
      check32($sformatf("strm%0d_addr", i),  mem_addr,  {a[31:2], 2'b00});
      check4 ($sformatf("strm%0d_be", i),    mem_be,    4'b0001 << a[1:0]);
      check32($sformatf("strm%0d_wdata", i), mem_wdata, {4{d}});
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    check1 ("strm_end_empty", empty, 1'b1);

    // Reset with two entries queued
    mem_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_0900, 32'hAAAA_0000);
    tick();
    drive(1'b1, 2'b00, 32'h0000_0A00, 32'hBBBB_0000);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check1 ("pre_rst_in_ready", in_ready,  1'b0);
    check1 ("pre_rst_valid",    mem_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1 ("mid_rst_valid",    mem_valid, 1'b0);
    check1 ("mid_rst_empty",    empty,     1'b1);
    check1 ("mid_rst_in_ready", in_ready,  1'b1);
    tick();
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    tick();
    check1 ("post_rst_valid1", mem_valid, 1'b0);
    tick();
    check1 ("post_rst_valid2", mem_valid, 1'b0);
    check1 ("post_rst_empty",  empty,     1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_align_buffer.md
# store_align_buffer

Store-side counterpart of the load data extender: it takes processor store requests (word, halfword, byte) with their byte address, produces word-aligned memory writes with replicated lane data and byte enables, and queues them in a small write buffer in front of the data memory port. Misaligned or reserved-op stores are rejected with a one-cycle error pulse instead of being written. It sits between the MEM-stage store path and the data memory or bus interface.

## Interface
- DEPTH, 2, number of buffer entries; power of two, at least 2.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  store request present.
- in_ready  output  1  buffer can accept a request this cycle.
- in_addr  input  32  byte address of the store.
- in_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- in_op  input  2  00 = word (sw), 01 = byte (sb), 10 = halfword (sh), 11 = reserved.
- mem_valid  output  1  head entry presented to memory.
- mem_ready  input  1  memory accepts the head entry this cycle.
- mem_addr  output  32  word address: {addr[31:2], 2'b00}.
- mem_wdata  output  32  lane-replicated write data.
- mem_be  output  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- err_valid  output  1  one-cycle pulse: last accepted request was rejected.
- err_addr  output  32  byte address of the rejected request; held until the next rejection.
- empty  output  1  buffer holds no entries; used by the pipeline for load/store ordering.

## Operation
- Accept: a handshake occurs when in_valid && in_ready. in_ready = (count < DEPTH). There is no pass-through when full, even if a pop happens in the same cycle.
- Alignment check at accept time:
  - word requires A[1:0] = 00.
  - half requires A[0] = 0.
  - byte is always legal.
  - op 11 is always illegal.
- Illegal request: it is consumed by the handshake but not enqueued. Next edge sets err_valid = 1 and err_addr = in_addr. err_valid clears the following edge unless another rejection occurs.
- Legal request: enqueue {in_addr[31:2], be, wdata} at the tail.
- Lane rules (A = in_addr[1:0]):
  - word: be = 1111, wdata = in_data.
  - half: be = 0011 if A[1] = 0, otherwise 1100; wdata = {2{in_data[15:0]}}.
  - byte: be = 0001 << A; wdata = {4{in_data[7:0]}}.
- Drain: mem_valid = (count != 0). mem_addr, mem_wdata and mem_be come from the head entry. Pop on mem_valid && mem_ready.
- Bookkeeping: count, head and tail pointers wrap modulo DEPTH. A simultaneous legal push and pop leaves count unchanged. Entries leave strictly in FIFO order.
- empty = (count == 0).

## Timing
- Reset (async assert, sync release is the integrator's concern):
  - count = 0; head and tail pointers = 0.
  - mem_valid = 0, mem_addr, mem_wdata and mem_be = 0.
  - err_valid = 0, err_addr = 0.
  - in_ready = 1, empty = 1.
  - Reset mid-transfer discards all queued entries without any memory write.
- Latency: a legal request accepted at edge N into an empty buffer gives mem_valid = 1 from edge N to edge N+1, i.e. it is visible in the cycle after acceptance. Error latency is the same: err_valid is high for exactly one cycle after the accepting edge.
- Stability: while mem_valid && !mem_ready, mem_addr, mem_wdata and mem_be hold constant.
- Throughput: one accept and one pop per cycle sustained when not full.
- Full: when count = DEPTH, in_ready = 0. A pop at edge N raises in_ready after edge N.
- Rejected requests never affect count, mem_*, or empty.

## Test plan
- Reset then sb at 0x1003 with data 0x000000A5 -> next cycle mem_valid = 1, mem_addr = 0x1000, mem_be = 1000, mem_wdata = 0xA5A5A5A5, empty = 0.
- sh at 0x2002 with data 0x0000BEEF, mem_ready = 1 -> mem_be = 1100, mem_wdata = 0xBEEFBEEF, popped after one cycle, empty = 1 again.
- sw at 0x3001 -> err_valid pulses for 1 cycle, err_addr = 0x3001, mem_valid stays 0. Then op = 11 at 0x4000 -> second pulse with err_addr = 0x4000.
- mem_ready = 0, push three legal stores with DEPTH = 2:
  - in_ready drops after the second accept and the third request waits.
  - Raise mem_ready: entries drain in order, the third is accepted after the first pop, and mem_* stay stable while stalled.
- Full buffer with mem_ready = 1 and in_valid held for 8 stores -> in-order output with no loss or duplication, and the pointers wrap correctly.
- Assert rst_n low with 2 entries queued -> immediately mem_valid = 0, empty = 1, in_ready = 1, and no further writes occur after release.
